water_cycle_sequencer: RTL and testbench

- Fill/soak/drain sequencer sitting directly upstream of the water flow monitor.
- Drives the fill valve and drain pump, and supplies the monitor's `mode` and `reset` inputs.
- Consumes the monitor's `error_flag` and the shared 10-bit water level sensor.
- Latches a fault and shuts all actuators off on a flow error or phase timeout.

---
 rtl/water_cycle_sequencer_if.sv | 30 +++
 rtl/water_cycle_sequencer.sv | 135 +++++++++++++
 tb/tb_water_cycle_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/water_cycle_sequencer_if.sv
// Sequencer bus: command/sensor inputs and actuator/status outputs of the
// fill/soak/drain sequencer. The controller side drives the inputs and the
// sequencer side drives the outputs.
interface water_cycle_sequencer_if;
  logic       start;
  logic       clear_fault;
  logic [9:0] water_level_sensor;
  logic       flow_error;
  logic       fill_valve;
  logic       drain_pump;
  logic       monitor_mode;
  logic       monitor_rst;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  modport master (
    output start, clear_fault, water_level_sensor, flow_error,
    input  fill_valve, drain_pump, monitor_mode, monitor_rst,
           busy, done, fault, fault_code, state
  );

  modport slave (
    input  start, clear_fault, water_level_sensor, flow_error,
    output fill_valve, drain_pump, monitor_mode, monitor_rst,
           busy, done, fault, fault_code, state
  );
endinterface

// File: rtl/water_cycle_sequencer.sv
// Fill/soak/drain sequencer placed upstream of the water flow monitor.
// All outputs are decoded from the next state and registered, so the
// actuators change only on a clock edge (or drop at once on reset).
module water_cycle_sequencer #(
  parameter int FILL_TARGET     = 600,
  parameter int DRAIN_TARGET    = 30,
  parameter int SOAK_TICKS      = 10,
  parameter int MAX_PHASE_TICKS = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  water_cycle_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_SOAK  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  localparam logic [9:0]  FILL_LVL   = 10'(FILL_TARGET);
  localparam logic [9:0]  DRAIN_LVL  = 10'(DRAIN_TARGET);
  localparam logic [15:0] SOAK_LAST  = 16'(SOAK_TICKS - 1);
  localparam logic [15:0] PHASE_LAST = 16'(MAX_PHASE_TICKS - 1);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_FLOW    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] cnt_q;
  logic        fill_q, drain_q, mode_q, mrst_q, busy_q, done_q, fault_q;
  logic        mrst_d;

  // Next-state and fault-code selection; target beats error beats timeout.
  // The monitor error is only trusted once the monitor is out of reset,
  // i.e. from the second cycle of a FILL or DRAIN phase.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FILL;
      end
      S_FILL: begin
        if (bus.water_level_sensor >= FILL_LVL) begin
          state_d = S_SOAK;
        end else if (bus.flow_error && !mrst_q) begin
          state_d = S_FAULT;
          code_d  = CODE_FLOW;
        end else if (cnt_q == PHASE_LAST) begin
          state_d = S_FAULT;
          code_d  = CODE_TIMEOUT;
        end
      end
      S_SOAK: begin
        if (cnt_q == SOAK_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.water_level_sensor <= DRAIN_LVL) begin
          state_d = S_DONE;
        end else if (bus.flow_error && !mrst_q) begin
          state_d = S_FAULT;
          code_d  = CODE_FLOW;
        end else if (cnt_q == PHASE_LAST) begin
          state_d = S_FAULT;
          code_d  = CODE_TIMEOUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (bus.clear_fault) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The code is only meaningful in FAULT; leaving through IDLE wipes it.
    if (state_d == S_IDLE) code_d = CODE_NONE;
  end

  // Monitor is held in reset everywhere except after the first cycle of a
  // FILL or DRAIN phase, so it starts each active phase from a clean slate.
  always_comb begin
    mrst_d = 1'b1;
    if ((state_d == S_FILL || state_d == S_DRAIN) && state_d == state_q)
      mrst_d = 1'b0;
  end

  // State, phase counter and registered output decode of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= CODE_NONE;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      drain_q <= 1'b0;
      mode_q  <= 1'b1;
      mrst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != '1)    cnt_q <= cnt_q + 16'd1;
      // FILL and DRAIN are never adjacent, so these two never overlap.
      fill_q  <= (state_d == S_FILL);
      drain_q <= (state_d == S_DRAIN);
      mode_q  <= (state_d != S_DRAIN);
      mrst_q  <= mrst_d;
      busy_q  <= (state_d == S_FILL) || (state_d == S_SOAK) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign bus.fill_valve   = fill_q;
  assign bus.drain_pump   = drain_q;
  assign bus.monitor_mode = mode_q;
  assign bus.monitor_rst  = mrst_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fault        = fault_q;
  assign bus.fault_code   = code_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_water_cycle_sequencer.sv
// Self-checking bench for water_cycle_sequencer: a vector table for the
// fault/ignored-input paths plus hand-written sequences for the full cycle,
// timeout, simultaneous events and asynchronous reset.
module tb_water_cycle_sequencer;

  logic clk;
  logic reset;
  water_cycle_sequencer_if ifc ();

  water_cycle_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       fv, dp, mm, mr, busy, done, fault;
    logic [1:0] code;
  } obs_t;

  typedef struct {
    logic       st, cl;
    int         lvl;
    logic       fe;
    int         es;
    bit         emr;
    int         ec;
  } vec_t;

  int   n_total = 0;
  int   n_pass  = 0;
  int   done_cnt = 0;
  obs_t sb_q[$];
  vec_t tbl[12];

  // Expected outputs for a state, from the documented output decode.
  function automatic obs_t ex(int s, bit mr, int code);
    obs_t o;
    o.st    = 3'(s);
    o.fv    = (s == 1);
    o.dp    = (s == 3);
    o.mm    = (s != 3);
    o.mr    = mr;
    o.busy  = (s >= 1 && s <= 3);
    o.done  = (s == 4);
    o.fault = (s == 5);
    o.code  = 2'(code);
    return o;
  endfunction

  function automatic obs_t got();
    obs_t o;
    o.st = ifc.state; o.fv = ifc.fill_valve; o.dp = ifc.drain_pump;
    o.mm = ifc.monitor_mode; o.mr = ifc.monitor_rst; o.busy = ifc.busy;
    o.done = ifc.done; o.fault = ifc.fault; o.code = ifc.fault_code;
    return o;
  endfunction

  task automatic check(string nm, obs_t a, obs_t e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b want %b (st,fv,dp,mm,mr,busy,done,fault,code)",
                  nm, a, e);
    n_total++;
    if (!(a.fv && a.dp)) n_pass++;
    else $display("FAIL %s interlock: fill_valve=%b drain_pump=%b want not both 1",
                  nm, a.fv, a.dp);
  endtask

  // One clock: drive inputs at negedge, queue the expectation, compare
  // what the DUT shows just after the rising edge.
  task automatic cyc(string nm, logic st, logic cl, int lvl, logic fe,
                     int es, bit emr, int ec);
    obs_t a, e;
    @(negedge clk);
    ifc.start = st; ifc.clear_fault = cl;
    ifc.water_level_sensor = 10'(lvl); ifc.flow_error = fe;
    sb_q.push_back(ex(es, emr, ec));
    @(posedge clk);
    #1;
    a = got();
    e = sb_q.pop_front();
    if (a.done) done_cnt++;
    check(nm, a, e);
  endtask

  task automatic soak_run(string nm);
    for (int j = 0; j < 10; j++)
      cyc(nm, 1'(j % 2), 1'b0, 600, 1'b0, (j == 9) ? 3 : 2, 1'b1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // start, clear, level, ferr, exp state, exp monitor_rst, exp code
    tbl[0]  = '{0, 1, 100, 0, 0, 1, 0};  // clear_fault in IDLE ignored
    tbl[1]  = '{1, 0, 100, 0, 1, 1, 0};  // start -> FILL, monitor in reset
    tbl[2]  = '{0, 0, 100, 1, 1, 0, 0};  // error in first FILL cycle ignored
    tbl[3]  = '{0, 0, 100, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 100, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 100, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 100, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 100, 1, 5, 1, 1};  // FILL cycle 5 error -> FAULT 01
    tbl[8]  = '{1, 0, 100, 0, 5, 1, 1};  // start ignored in FAULT
    tbl[9]  = '{0, 0, 700, 1, 5, 1, 1};  // code holds
    tbl[10] = '{0, 1, 100, 0, 0, 1, 0};  // clear -> IDLE, code 00
    tbl[11] = '{0, 0, 100, 0, 0, 1, 0};

    reset = 1'b0;
    ifc.start = 1'b0; ifc.clear_fault = 1'b0;
    ifc.water_level_sensor = '0; ifc.flow_error = 1'b0;
    #12;
    check("reset", got(), ex(0, 1, 0));
    @(negedge clk);
    reset = 1'b1;

    // Normal cycle: level +20 per FILL cycle, hold in SOAK, -20 in DRAIN.
    done_cnt = 0;
    cyc("t1 start", 1'b1, 1'b0, 50, 1'b0, 1, 1'b1, 0);
    for (int k = 0; k < 40; k++) begin
      int lvl, es;
      lvl = 70 + 20 * k;
      es  = (lvl >= 600) ? 2 : 1;
      cyc("t1 fill", 1'b0, 1'b0, lvl, 1'b0, es, es == 2, 0);
      if (es == 2) break;
    end
    soak_run("t1 soak");
    for (int d = 0; d < 40; d++) begin
      int lvl, es;
      lvl = 590 - 20 * d;
      es  = (lvl <= 30) ? 4 : 3;
      cyc("t1 drain", 1'b0, 1'b0, lvl, 1'b0, es, es == 4, 0);
      if (es == 4) break;
    end
    cyc("t1 done->idle", 1'b0, 1'b0, 30, 1'b0, 0, 1'b1, 0);
    n_total++;
    if (done_cnt == 1) n_pass++;
    else $display("FAIL t1 done pulses: got %0d want 1", done_cnt);

    // Flow error in FILL, ignored inputs, clear_fault.
    for (int i = 0; i < 12; i++)
      cyc($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].cl, tbl[i].lvl,
          tbl[i].fe, tbl[i].es, tbl[i].emr, tbl[i].ec);

    // Fill timeout: 100 FILL cycles then FAULT code 10.
    cyc("t3 start", 1'b1, 1'b0, 50, 1'b0, 1, 1'b1, 0);
    for (int k = 0; k < 100; k++)
      cyc("t3 fill", 1'b0, 1'b0, 51 + k, 1'b0, (k == 99) ? 5 : 1,
          k == 99, (k == 99) ? 2 : 0);
    cyc("t3 clear", 1'b0, 1'b1, 150, 1'b0, 0, 1'b1, 0);

    // Already at target on FILL entry; target wins over error in DRAIN;
    // start held through DONE restarts one cycle after IDLE.
    cyc("t4 start", 1'b1, 1'b0, 50, 1'b0, 1, 1'b1, 0);
    cyc("t4 fill at target", 1'b0, 1'b0, 600, 1'b0, 2, 1'b1, 0);
    soak_run("t4 soak");
    cyc("t4 drain", 1'b0, 1'b0, 100, 1'b0, 3, 1'b0, 0);
    cyc("t4 drain", 1'b0, 1'b0, 100, 1'b0, 3, 1'b0, 0);
    cyc("t4 target+error", 1'b1, 1'b0, 30, 1'b1, 4, 1'b1, 0);
    cyc("t6 start in DONE", 1'b1, 1'b0, 30, 1'b0, 0, 1'b1, 0);
    cyc("t6 start in IDLE", 1'b1, 1'b0, 30, 1'b0, 1, 1'b1, 0);

    // Asynchronous reset between edges during DRAIN.
    cyc("t5 fill", 1'b0, 1'b0, 600, 1'b0, 2, 1'b1, 0);
    soak_run("t5 soak");
    cyc("t5 drain", 1'b0, 1'b0, 200, 1'b0, 3, 1'b0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t5 async reset", got(), ex(0, 1, 0));
    @(negedge clk);
    reset = 1'b1;
    cyc("t5 idle after reset", 1'b0, 1'b0, 200, 1'b0, 0, 1'b1, 0);
    cyc("t5 idle after reset", 1'b0, 1'b0, 200, 1'b0, 0, 1'b1, 0);
    cyc("t5 restart", 1'b1, 1'b0, 200, 1'b0, 1, 1'b1, 0);
    cyc("t5 fill", 1'b0, 1'b0, 600, 1'b0, 2, 1'b1, 0);
    soak_run("t5 soak");
    cyc("t5 drain at target", 1'b0, 1'b0, 20, 1'b0, 4, 1'b1, 0);
    cyc("t5 idle", 1'b0, 1'b0, 20, 1'b0, 0, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
